// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer for the single-hart core.
//
// Detects ECALL, illegal instructions, MRET and enabled timer/external interrupts
// on the cycle an instruction commits. It then runs a fixed sequence: flush plus
// CSR update (CAPTURE), then PC redirect (REDIRECT). This block is the only
// writer of the non-instruction CSR updates.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   commit_*               committing instruction: valid, pc, next pc, ecall/illegal/mret flags
//   irq_timer, irq_ext     level interrupt requests (MTIP, MEIP)
//   mstatus_in, mie_in,
//   mtvec_in, mepc_in      current CSR values
//   busy                   stall commit/fetch
//   flush                  one-cycle pipeline flush
//   trap_we, trap_mepc,
//   trap_mcause            mepc/mcause write port
//   mstatus_we,
//   mstatus_wdata          mstatus write port
//   redirect_valid/pc/ready  valid/ready handshake for the new PC
module trap_ctrl #(
    parameter int unsigned XLEN              = 32,
    parameter bit          MTVEC_VECTORED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [XLEN-1:0] commit_next_pc,
    input  logic            commit_ecall,
    input  logic            commit_illegal,
    input  logic            commit_mret,
    input  logic            irq_timer,
    input  logic            irq_ext,
    input  logic [XLEN-1:0] mstatus_in,
    input  logic [XLEN-1:0] mie_in,
    input  logic [XLEN-1:0] mtvec_in,
    input  logic [XLEN-1:0] mepc_in,
    output logic            busy,
    output logic            flush,
    output logic            trap_we,
    output logic [XLEN-1:0] trap_mepc,
    output logic [XLEN-1:0] trap_mcause,
    output logic            mstatus_we,
    output logic [XLEN-1:0] mstatus_wdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready
);

    localparam logic [XLEN-1:0] CauseExt     = {1'b1, {(XLEN-5){1'b0}}, 4'd11};
    localparam logic [XLEN-1:0] CauseTimer   = {1'b1, {(XLEN-5){1'b0}}, 4'd7};
    localparam logic [XLEN-1:0] CauseIllegal = {{(XLEN-4){1'b0}}, 4'd2};
    localparam logic [XLEN-1:0] CauseEcall   = {{(XLEN-4){1'b0}}, 4'd11};

    typedef enum logic [1:0] {StIdle, StCapture, StRedirect} state_e;

    state_e          state_q, state_d;
    logic            is_mret_q, is_mret_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] target_q, target_d;

    // Event decode, only meaningful in IDLE with a committing instruction.
    logic            int_pend;
    logic            take_ext, take_timer;
    logic            accept;
    logic            is_int;
    logic [XLEN-1:0] cause_sel;
    logic [XLEN-1:0] mepc_sel;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] trap_target;

    logic unused_mie;
    assign unused_mie = ^{mie_in[XLEN-1:12], mie_in[10:8], mie_in[6:0]};

    always_comb begin
        int_pend   = mstatus_in[3] & ((irq_ext & mie_in[11]) | (irq_timer & mie_in[7]));
        take_ext   = int_pend & irq_ext & mie_in[11];
        take_timer = int_pend & ~take_ext;
        is_int     = take_ext | take_timer;
        accept     = (state_q == StIdle) & commit_valid &
                     (int_pend | commit_illegal | commit_ecall | commit_mret);

        // Interrupts resume after the committed instruction, exceptions re-execute it.
        if (take_ext) begin
            cause_sel = CauseExt;
            mepc_sel  = commit_next_pc;
        end else if (take_timer) begin
            cause_sel = CauseTimer;
            mepc_sel  = commit_next_pc;
        end else if (commit_illegal) begin
            cause_sel = CauseIllegal;
            mepc_sel  = commit_pc;
        end else begin
            cause_sel = CauseEcall;
            mepc_sel  = commit_pc;
        end

        tvec_base = {mtvec_in[XLEN-1:2], 2'b00};
        if (MTVEC_VECTORED_EN && is_int && (mtvec_in[1:0] == 2'b01)) begin
            trap_target = tvec_base + XLEN'({cause_sel[4:0], 2'b00});
        end else begin
            trap_target = tvec_base;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            is_mret_q <= 1'b0;
            cause_q   <= '0;
            mepc_q    <= '0;
            target_q  <= '0;
        end else begin
            state_q   <= state_d;
            is_mret_q <= is_mret_d;
            cause_q   <= cause_d;
            mepc_q    <= mepc_d;
            target_q  <= target_d;
        end
    end

    // Next state
    always_comb begin
        state_d   = state_q;
        is_mret_d = is_mret_q;
        cause_d   = cause_q;
        mepc_d    = mepc_q;
        target_d  = target_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StCapture;
                    // MRET only wins when nothing of higher priority is present.
                    if (!is_int && !commit_illegal && !commit_ecall) begin
                        is_mret_d = 1'b1;
                        cause_d   = '0;
                        mepc_d    = '0;
                        target_d  = mepc_in;
                    end else begin
                        is_mret_d = 1'b0;
                        cause_d   = cause_sel;
                        mepc_d    = mepc_sel;
                        target_d  = trap_target;
                    end
                end
            end
            StCapture: state_d = StRedirect;
            StRedirect: begin
                if (redirect_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; forced low while rst is high so no partial CSR write escapes.
    always_comb begin
        busy           = 1'b0;
        flush          = 1'b0;
        trap_we        = 1'b0;
        trap_mepc      = '0;
        trap_mcause    = '0;
        mstatus_we     = 1'b0;
        mstatus_wdata  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (!rst) begin
            unique case (state_q)
                StIdle: busy = accept;
                StCapture: begin
                    busy          = 1'b1;
                    flush         = 1'b1;
                    mstatus_we    = 1'b1;
                    mstatus_wdata = mstatus_in;
                    mstatus_wdata[12:11] = 2'b11;
                    if (is_mret_q) begin
                        mstatus_wdata[3] = mstatus_in[7];
                        mstatus_wdata[7] = 1'b1;
                    end else begin
                        trap_we          = 1'b1;
                        trap_mepc        = mepc_q;
                        trap_mcause      = cause_q;
                        mstatus_wdata[7] = mstatus_in[3];
                        mstatus_wdata[3] = 1'b0;
                    end
                end
                StRedirect: begin
                    busy           = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc    = target_q;
                end
                default: busy = 1'b0;
            endcase
        end
    end

    // Commit while the sequencer is busy is a protocol violation; it is ignored.
    assert property (@(posedge clk) disable iff (rst) (state_q != StIdle) |-> !commit_valid);

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic [31:0] commit_pc, commit_next_pc;
    logic        commit_ecall, commit_illegal, commit_mret;
    logic        irq_timer, irq_ext;
    logic [31:0] mstatus_in, mie_in, mtvec_in, mepc_in;
    logic        busy, flush, trap_we, mstatus_we, redirect_valid, redirect_ready;
    logic [31:0] trap_mepc, trap_mcause, mstatus_wdata, redirect_pc;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(32), .MTVEC_VECTORED_EN(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_next_pc (commit_next_pc),
        .commit_ecall   (commit_ecall),
        .commit_illegal (commit_illegal),
        .commit_mret    (commit_mret),
        .irq_timer      (irq_timer),
        .irq_ext        (irq_ext),
        .mstatus_in     (mstatus_in),
        .mie_in         (mie_in),
        .mtvec_in       (mtvec_in),
        .mepc_in        (mepc_in),
        .busy           (busy),
        .flush          (flush),
        .trap_we        (trap_we),
        .trap_mepc      (trap_mepc),
        .trap_mcause    (trap_mcause),
        .mstatus_we     (mstatus_we),
        .mstatus_wdata  (mstatus_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    typedef struct {
        logic        is_trap;
        logic [31:0] mepc;
        logic [31:0] cause;
        logic [31:0] wdata;
    } cap_t;

    cap_t        cap_q[$];
    logic [31:0] redir_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a CSR write or a redirect.
    always @(negedge clk) begin
        if (mstatus_we) begin
            if (cap_q.size() == 0) begin
                chk("unexpected_capture", 32'(mstatus_we), 32'd0);
            end else begin
                cap_t e;
                e = cap_q.pop_front();
                chk("cap_flush", 32'(flush), 32'd1);
                chk("cap_trap_we", 32'(trap_we), 32'(e.is_trap));
                chk("cap_mstatus_wdata", mstatus_wdata, e.wdata);
                if (e.is_trap) begin
                    chk("cap_mepc", trap_mepc, e.mepc);
                    chk("cap_mcause", trap_mcause, e.cause);
                end
            end
        end
        if (redirect_valid && redirect_ready) begin
            if (redir_q.size() == 0) begin
                chk("unexpected_redirect", 32'(redirect_valid), 32'd0);
            end else begin
                chk("redirect_pc", redirect_pc, redir_q.pop_front());
            end
        end
    end

    task automatic push_trap(input logic [31:0] mepc, cause, wdata, target);
        cap_t e;
        e.is_trap = 1'b1; e.mepc = mepc; e.cause = cause; e.wdata = wdata;
        cap_q.push_back(e);
        redir_q.push_back(target);
    endtask

    task automatic push_mret(input logic [31:0] wdata, target);
        cap_t e;
        e.is_trap = 1'b0; e.mepc = '0; e.cause = '0; e.wdata = wdata;
        cap_q.push_back(e);
        redir_q.push_back(target);
    endtask

    // Drives one commit cycle; returns just after the acceptance edge (DUT in CAPTURE).
    task automatic do_event(input logic [31:0] pc, npc, input logic ec, il, mr);
        @(posedge clk); #1;
        commit_valid = 1'b1; commit_pc = pc; commit_next_pc = npc;
        commit_ecall = ec; commit_illegal = il; commit_mret = mr;
        @(negedge clk);
        chk("busy_on_accept", 32'(busy), 32'd1);
        @(posedge clk); #1;
        commit_valid = 1'b0; commit_ecall = 1'b0; commit_illegal = 1'b0; commit_mret = 1'b0;
        irq_timer = 1'b0; irq_ext = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        rst = 1'b1; commit_valid = 1'b0; commit_pc = '0; commit_next_pc = '0;
        commit_ecall = 1'b0; commit_illegal = 1'b0; commit_mret = 1'b0;
        irq_timer = 1'b0; irq_ext = 1'b0; mstatus_in = '0; mie_in = '0;
        mtvec_in = '0; mepc_in = '0; redirect_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_trap_we", 32'(trap_we), 32'd0);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);

        // ECALL, direct mtvec; back in IDLE three cycles after acceptance.
        mstatus_in = 32'h8; mtvec_in = 32'h200;
        push_trap(32'h100, 32'd11, 32'h1880, 32'h200);
        do_event(32'h100, 32'h104, 1'b1, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("ecall_idle_after_3", 32'(busy), 32'd0);

        // MRET: target is mepc_in at acceptance, later changes must not matter.
        mstatus_in = 32'h80; mepc_in = 32'h104;
        push_mret(32'h1888, 32'h104);
        do_event(32'h108, 32'h10C, 1'b0, 1'b0, 1'b1);
        mepc_in = 32'hDEAD_BEE0;
        wait_idle();

        // External irq beats illegal; vectored mtvec gives base + 4*11.
        mstatus_in = 32'h8; mie_in = 32'h800; irq_ext = 1'b1; mtvec_in = 32'h201;
        push_trap(32'h44, 32'h8000_000B, 32'h1880, 32'h22C);
        do_event(32'h40, 32'h44, 1'b0, 1'b1, 1'b0);
        wait_idle();

        // Illegal alone with vectored mtvec: exceptions always go to the base.
        mtvec_in = 32'h301;
        push_trap(32'h50, 32'd2, 32'h1880, 32'h300);
        do_event(32'h50, 32'h54, 1'b0, 1'b1, 1'b0);
        wait_idle();

        // Timer irq vectored then direct.
        mie_in = 32'h80; irq_timer = 1'b1;
        push_trap(32'h64, 32'h8000_0007, 32'h1880, 32'h31C);
        do_event(32'h60, 32'h64, 1'b0, 1'b0, 1'b0);
        wait_idle();
        mtvec_in = 32'h300; irq_timer = 1'b1;
        push_trap(32'h68, 32'h8000_0007, 32'h1880, 32'h300);
        do_event(32'h64, 32'h68, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // Timer with MIE=0: plain commit, no trap.
        mstatus_in = 32'h0; irq_timer = 1'b1;
        @(posedge clk); #1 commit_valid = 1'b1; commit_pc = 32'h70; commit_next_pc = 32'h74;
        @(negedge clk);
        chk("mie0_no_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 commit_valid = 1'b0; mstatus_in = 32'h8;
        // MIE=1 but no commit: still nothing.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_commit_no_busy", 32'(busy), 32'd0);
        end
        mtvec_in = 32'h200;
        push_trap(32'h78, 32'h8000_0007, 32'h1880, 32'h200);
        do_event(32'h74, 32'h78, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // Redirect held for 5 cycles: valid and pc stay put.
        redirect_ready = 1'b0;
        push_trap(32'h120, 32'd11, 32'h1880, 32'h200);
        do_event(32'h120, 32'h124, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_redirect_valid", 32'(redirect_valid), 32'd1);
            chk("stall_redirect_pc", redirect_pc, 32'h200);
        end
        @(posedge clk); #1 redirect_ready = 1'b1;
        wait_idle();

        // Reset while in REDIRECT: everything clears, no redirect handshake expected.
        redirect_ready = 1'b0;
        begin
            cap_t e;
            e.is_trap = 1'b1; e.mepc = 32'h180; e.cause = 32'd11; e.wdata = 32'h1880;
            cap_q.push_back(e);
        end
        do_event(32'h180, 32'h184, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_redirect_valid", 32'(redirect_valid), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("post_rst_redirect_pc", redirect_pc, 32'd0);
        chk("post_rst_we", 32'({trap_we, mstatus_we, flush}), 32'd0);
        redirect_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_still_idle", 32'(busy), 32'd0);

        chk("cap_queue_drained", 32'(cap_q.size()), 32'd0);
        chk("redir_queue_drained", 32'(redir_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
